// File: rtl/soc_reset_ctrl.sv
// rtl/soc_reset_ctrl.sv - stretched SoC core reset with selectable sources
//
// Purpose : synchronizes the external reset pin, combines it with the SPI
//           reset request under p_sel_rst, and stretches the resulting
//           core reset by RST_CYCLES cycles after the request releases.
// Macro   : SOC_RST_CAUSE_EN - when defined, p_rst_cause records the
//           source of the last reset; otherwise it is tied to 00.
// Ports   : p_clk          system clock
//           p_reset        synchronous active-high reset (power-on source)
//           p_sel_rst      source select: 00 por, 01 ext, 10 spi, 11 all
//           p_ext_rst_n    external reset pin, asynchronous, active-low
//           p_spi_rst      SPI reset request, synchronous, active-high
//           p_core_reset   stretched core reset, active-high
//           p_rst_release  one-cycle pulse after p_core_reset falls
//           p_rst_cause    last reset cause: 00 por, 01 ext, 10 spi
module soc_reset_ctrl #(
    parameter int RST_CYCLES  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       p_clk,
    input  logic       p_reset,
    input  logic [1:0] p_sel_rst,
    input  logic       p_ext_rst_n,
    input  logic       p_spi_rst,
    output logic       p_core_reset,
    output logic       p_rst_release,
    output logic [1:0] p_rst_cause
);

    localparam int CW = $clog2(RST_CYCLES);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_STRETCH = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   release_q, release_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ext_req;
    logic                   ext_hit;
    logic                   spi_hit;
    logic                   req;

    // Reset fills the synchronizer with 1s so the pin reads as released.
    always_ff @(posedge p_clk) begin
        if (p_reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], p_ext_rst_n};
        end
    end

    assign ext_req = ~sync_q[SYNC_STAGES-1];

    // Select bit 0 enables the external source, bit 1 the SPI source.
    assign ext_hit = p_sel_rst[0] & ext_req;
    assign spi_hit = p_sel_rst[1] & p_spi_rst;
    assign req     = ext_hit | spi_hit;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        release_d = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (req) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (!req) begin
                    state_d = ST_STRETCH;
                    cnt_d   = CW'(RST_CYCLES - 1);
                end
            end
            ST_STRETCH: begin
                if (req) begin
                    state_d = ST_ACTIVE;
                end else if (cnt_q == '0) begin
                    state_d   = ST_RUN;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_ACTIVE;
            end
        endcase
    end

    always_ff @(posedge p_clk) begin
        if (p_reset) begin
            state_q   <= ST_ACTIVE;
            cnt_q     <= CW'(RST_CYCLES - 1);
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            release_q <= release_d;
        end
    end

    assign p_core_reset  = (state_q != ST_RUN);
    assign p_rst_release = release_q;

`ifdef SOC_RST_CAUSE_EN
    logic [1:0] cause_q, cause_d;

    // Cause is captured only when leaving RUN; external wins a tie.
    always_comb begin
        cause_d = cause_q;
        if (state_q == ST_RUN && req) begin
            cause_d = ext_hit ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge p_clk) begin
        if (p_reset) begin
            cause_q <= 2'b00;
        end else begin
            cause_q <= cause_d;
        end
    end

    assign p_rst_cause = cause_q;
`else
    assign p_rst_cause = 2'b00;
`endif

endmodule

// File: tb/tb_soc_reset_ctrl.sv
// tb/tb_soc_reset_ctrl.sv - self-checking bench for soc_reset_ctrl
module tb_soc_reset_ctrl;

    localparam int RST  = 16;
    localparam int SYNC = 2;
`ifdef SOC_RST_CAUSE_EN
    localparam bit CE = 1'b1;
`else
    localparam bit CE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sel = 2'b00;
    logic       pin = 1'b1;
    logic       spi = 1'b0;
    logic       core, rel;
    logic [1:0] cause;

    int errors = 0;
    int checks = 0;

    // Reference: core reset is high while fewer than RST+1 edges have passed
    // since the last edge that saw a request or p_reset.
    int         cyc = 0;
    int         last = -100000;
    logic       m_core = 1'b1;
    logic       m_rel = 1'b0;
    logic [1:0] m_cause = 2'b00;
    logic       dly [SYNC];

    soc_reset_ctrl #(.RST_CYCLES(RST), .SYNC_STAGES(SYNC)) dut (
        .p_clk(clk), .p_reset(rst), .p_sel_rst(sel), .p_ext_rst_n(pin),
        .p_spi_rst(spi), .p_core_reset(core), .p_rst_release(rel),
        .p_rst_cause(cause)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < SYNC; i++) dly[i] = 1'b1;
    end

    task automatic step();
        logic ext, req;
        @(posedge clk);
        ext = !dly[SYNC-1];
        req = (sel[0] && ext) || (sel[1] && spi);
        if (rst) begin
            last    = cyc;
            m_cause = 2'b00;
        end else if (req) begin
            if (!m_core) m_cause = !CE ? 2'b00 : ((sel[0] && ext) ? 2'b01 : 2'b10);
            last = cyc;
        end
        m_core = (cyc - last) <= RST;
        m_rel  = (cyc - last) == RST + 1;
        for (int i = SYNC - 1; i > 0; i--) dly[i] = rst ? 1'b1 : dly[i-1];
        dly[0] = rst ? 1'b1 : pin;
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        rst = 0; spi = 0; pin = 1;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        int highs, rels, rel_at;
        rst = 1; sel = 0; pin = 1; spi = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (core !== 1'b1 || rel !== 1'b0 || cause !== 2'b00) begin
                errors++;
                $display("FAIL reset_hold: core=%b rel=%b cause=%b required 1 0 00", core, rel, cause);
            end
        end
        rst = 0; highs = 0; rels = 0; rel_at = -1;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (core === 1'b1) highs++;
            if (rel === 1'b1) begin rels++; rel_at = i; end
        end
        checks++;
        if (highs != RST) begin
            errors++;
            $display("FAIL por_stretch: high=%0d required %0d", highs, RST);
        end
        checks++;
        if (rels != 1 || rel_at != RST + 1) begin
            errors++;
            $display("FAIL por_release: pulses=%0d at=%0d required 1 at %0d", rels, rel_at, RST + 1);
        end
        checks++;
        if (cause !== 2'b00) begin
            errors++;
            $display("FAIL por_cause: cause=%b required 00", cause);
        end
    endtask

    task automatic test_ext_pin();
        int rise, highs;
        sel = 2'b01; idle(4);
        rise = -1; highs = 0;
        for (int i = 1; i <= 40; i++) begin
            pin = (i <= 5) ? 1'b0 : 1'b1;
            step();
            if (core === 1'b1) begin
                highs++;
                if (rise < 0) rise = i;
            end
        end
        checks++;
        if (rise != SYNC + 1) begin
            errors++;
            $display("FAIL ext_latency: rise=%0d required %0d", rise, SYNC + 1);
        end
        checks++;
        if (highs != 5 + RST) begin
            errors++;
            $display("FAIL ext_duration: high=%0d required %0d", highs, 5 + RST);
        end
        checks++;
        if (cause !== (CE ? 2'b01 : 2'b00)) begin
            errors++;
            $display("FAIL ext_cause: cause=%b required %b", cause, CE ? 2'b01 : 2'b00);
        end
    endtask

    task automatic test_sel_mask();
        int highs, rise;
        sel = 2'b00; idle(2); highs = 0;
        for (int i = 1; i <= 25; i++) begin
            spi = (i == 1);
            step();
            if (core === 1'b1) highs++;
        end
        checks++;
        if (highs != 0) begin
            errors++;
            $display("FAIL sel_masked: high=%0d required 0", highs);
        end
        sel = 2'b10; highs = 0; rise = -1;
        for (int i = 1; i <= 25; i++) begin
            spi = (i == 1);
            step();
            if (core === 1'b1) begin
                highs++;
                if (rise < 0) rise = i;
            end
        end
        checks++;
        if (highs != RST + 1 || rise != 1) begin
            errors++;
            $display("FAIL spi_pulse: high=%0d rise=%0d required %0d rise 1", highs, rise, RST + 1);
        end
        checks++;
        if (cause !== (CE ? 2'b10 : 2'b00)) begin
            errors++;
            $display("FAIL spi_cause: cause=%b required %b", cause, CE ? 2'b10 : 2'b00);
        end
    endtask

    task automatic test_retrigger();
        int highs;
        sel = 2'b10; idle(2); highs = 0;
        for (int i = 1; i <= 40; i++) begin
            spi = (i == 1 || i == 12);
            step();
            if (core === 1'b1) highs++;
        end
        checks++;
        if (highs != 1 + 10 + 1 + RST) begin
            errors++;
            $display("FAIL retrigger: high=%0d required %0d", highs, 12 + RST);
        end
    endtask

    task automatic test_simultaneous();
        sel = 2'b11; idle(2);
        for (int i = 1; i <= 30; i++) begin
            pin = (i <= 3) ? 1'b0 : 1'b1;
            spi = (i == SYNC + 1);
            step();
        end
        checks++;
        if (cause !== (CE ? 2'b01 : 2'b00)) begin
            errors++;
            $display("FAIL simul_cause: cause=%b required %b", cause, CE ? 2'b01 : 2'b00);
        end
    endtask

    task automatic test_mid_reset();
        int highs;
        sel = 2'b10; idle(2);
        spi = 1; step(); spi = 0;
        for (int i = 0; i < 6; i++) step();
        rst = 1; step(); rst = 0;
        checks++;
        if (core !== 1'b1 || cause !== 2'b00 || rel !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: core=%b cause=%b rel=%b required 1 00 0", core, cause, rel);
        end
        highs = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (core === 1'b1) highs++;
        end
        checks++;
        if (highs != RST) begin
            errors++;
            $display("FAIL mid_reset_stretch: high=%0d required %0d", highs, RST);
        end
    endtask

    task automatic test_random();
        int pin_low = 0;
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 59) == 0) sel = 2'($urandom_range(0, 3));
            if (pin_low == 0 && $urandom_range(0, 79) == 0) pin_low = $urandom_range(1, 8);
            pin = (pin_low > 0) ? 1'b0 : 1'b1;
            if (pin_low > 0) pin_low--;
            spi = ($urandom_range(0, 49) == 0) ? 1'b1 : ($urandom_range(0, 199) == 0 ? spi : 1'b0);
            step();
            checks++;
            if (core !== m_core || rel !== m_rel || cause !== m_cause) begin
                errors++;
                $display("FAIL random cyc=%0d: core=%b rel=%b cause=%b required %b %b %b",
                         cyc, core, rel, cause, m_core, m_rel, m_cause);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ext_pin();
        test_sel_mask();
        test_retrigger();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
